// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - memory-mapped 8N1 UART receiver with FWFT receive FIFO
//
// Samples rx_line through a two-flop synchronizer, deframes 8N1 characters at a
// CPU-programmable bit period (divisor + 1 clocks) and buffers bytes in a FWFT FIFO.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   rx_line        asynchronous serial input, idles high
//   config_data    new divisor value (values below 3 are stored as 3)
//   config_enable  load divisor, clear sticky flags, abort the current frame
//   read_enable    pop the FIFO head
//   read_data      FIFO head, 0 when empty
//   data_available FIFO non-empty
//   overrun_error  sticky: a byte was dropped on a full FIFO
//   framing_error  sticky: a stop bit was sampled low
module rx_uart #(
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [7:0] DEFAULT_DIVISOR = 8'd103
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [7:0] config_data,
  input  logic       config_enable,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       data_available,
  output logic       overrun_error,
  output logic       framing_error
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  logic [7:0]    divisor;
  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic          push_req;
  logic          ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          overrun_set;

  // Half period floor((divisor+1)/2); the start check fires when cnt reaches half-1
  // because cnt is cleared on the edge that detects the falling edge.
  logic [8:0]    period;
  logic [7:0]    half_m1;
  assign period  = {1'b0, divisor} + 9'd1;
  assign half_m1 = period[8:1] - 8'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      divisor <= DEFAULT_DIVISOR;
    end else if (config_enable) begin
      divisor <= (config_data < 8'd3) ? 8'd3 : config_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 8'd1;
    bit_next   = bit_cnt;
    shift_next = shift;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = 8'd0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (cnt == half_m1) begin
          cnt_next   = 8'd0;
          bit_next   = 3'd0;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == divisor) begin
          cnt_next   = 8'd0;
          shift_next = {rx_s, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == divisor) begin
          cnt_next = 8'd0;
          if (rx_s) begin
            push_req   = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_next = 8'd0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // A configuration write aborts the frame and suppresses any push/flag on this edge.
    if (config_enable) begin
      state_next = S_IDLE;
      cnt_next   = 8'd0;
      push_req   = 1'b0;
      ferr_set   = 1'b0;
    end
  end

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = read_enable && !empty;
  // A simultaneous pop frees the slot the push lands in, so a full FIFO still accepts.
  assign push_ok     = push_req && (!full || pop);
  assign overrun_set = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else if (config_enable) begin
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (overrun_set) overrun_error <= 1'b1;
      if (ferr_set)    framing_error <= 1'b1;
    end
  end

  assign data_available = !empty;
  assign read_data      = empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - directed self-checking bench for rx_uart
module tb_rx_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic [7:0] config_data;
  logic       config_enable;
  logic       read_enable;
  logic [7:0] read_data;
  logic       data_available;
  logic       overrun_error;
  logic       framing_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int fall_cyc = 0;
  logic da_prev = 1'b0;

  rx_uart dut (
    .clk            (clk),
    .rst            (rst),
    .rx_line        (rx_line),
    .config_data    (config_data),
    .config_enable  (config_enable),
    .read_enable    (read_enable),
    .read_data      (read_data),
    .data_available (data_available),
    .overrun_error  (overrun_error),
    .framing_error  (framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One clock: sample outputs on the falling edge, return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (data_available && !da_prev && rise_cyc < 0) rise_cyc = cyc;
    da_prev = data_available;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_config(input logic [7:0] v);
    config_data   = v;
    config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
  endtask

  task automatic pop_byte();
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  // Drives one 8N1 frame; a bad stop bit holds the line low for low_hold clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int p, input int low_hold);
    rx_line  = 1'b0;
    fall_cyc = cyc;
    rise_cyc = -1;
    idle(p);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      idle(p);
    end
    if (stop_ok) begin
      rx_line = 1'b1;
      idle(p);
    end else begin
      rx_line = 1'b0;
      idle(low_hold);
      rx_line = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2000);
    @(negedge clk);
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL reset_da got %b want 0", data_available); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_rd got %h want 00", read_data); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun_error); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", framing_error); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, 104, 0);
    idle(4);
    checks++; if (rise_cyc - fall_cyc !== 991) begin errors++; $display("FAIL single_latency got %0d want 991", rise_cyc - fall_cyc); end
    @(negedge clk);
    checks++; if (read_data !== 8'hA5) begin errors++; $display("FAIL single_rd got %h want a5", read_data); end
    @(posedge clk); #1;
    pop_byte();
    @(negedge clk);
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL single_pop_da got %b want 0", data_available); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL single_pop_rd got %h want 00", read_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    write_config(8'd3);
    idle(4);
    for (int k = 1; k <= 6; k++) send_frame(8'(k), 1'b1, 4, 0);
    idle(10);
    @(negedge clk);
    checks++; if (overrun_error !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun_error); end
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      exp = 8'(k);
      @(negedge clk);
      checks++; if (read_data !== exp) begin errors++; $display("FAIL b2b_order%0d got %h want %h", k, read_data, exp); end
      @(posedge clk); #1;
      pop_byte();
    end
    @(negedge clk);
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", data_available); end
    @(posedge clk); #1;
    send_frame(8'h07, 1'b1, 4, 0);
    idle(6);
    @(negedge clk);
    checks++; if (read_data !== 8'h07) begin errors++; $display("FAIL wrap_rd got %h want 07", read_data); end
    @(posedge clk); #1;
    pop_byte();
    write_config(8'd3);
    @(negedge clk);
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun_error); end
    @(posedge clk); #1;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 4, 120);
    idle(10);
    @(negedge clk);
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", framing_error); end
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL ferr_nopush got %b want 0", data_available); end
    @(posedge clk); #1;
    send_frame(8'h5A, 1'b1, 4, 0);
    idle(6);
    @(negedge clk);
    checks++; if (read_data !== 8'h5A) begin errors++; $display("FAIL after_break_rd got %h want 5a", read_data); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b want 1", framing_error); end
    @(posedge clk); #1;
    pop_byte();
  endtask

  task automatic test_glitch();
    write_config(8'd3);
    rx_line = 1'b0;
    tick();
    rx_line = 1'b1;
    idle(2 + 2 + 3);
    @(negedge clk);
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL glitch_da got %b want 0", data_available); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b want 0", framing_error); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL glitch_ovr got %b want 0", overrun_error); end
    @(posedge clk); #1;
    send_frame(8'h81, 1'b1, 4, 0);
    idle(6);
    @(negedge clk);
    checks++; if (read_data !== 8'h81) begin errors++; $display("FAIL glitch_next_rd got %h want 81", read_data); end
    @(posedge clk); #1;
    pop_byte();
  endtask

  task automatic test_reconfig();
    write_config(8'd15);
    idle(4);
    rx_line = 1'b0;
    idle(16);
    rx_line = 1'b1;
    idle(48 + 8);
    write_config(8'd1);
    idle(40);
    @(negedge clk);
    checks++; if (data_available !== 1'b0) begin errors++; $display("FAIL abort_da got %b want 0", data_available); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL abort_ferr got %b want 0", framing_error); end
    @(posedge clk); #1;
    send_frame(8'hC3, 1'b1, 4, 0);
    idle(6);
    checks++; if (rise_cyc - fall_cyc !== 41) begin errors++; $display("FAIL clamp_latency got %0d want 41", rise_cyc - fall_cyc); end
    @(negedge clk);
    checks++; if (read_data !== 8'hC3) begin errors++; $display("FAIL clamp_rd got %h want c3", read_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst           = 1'b0;
    rx_line       = 1'b1;
    config_data   = 8'd0;
    config_enable = 1'b0;
    read_enable   = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reconfig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
# rx_uart

Memory-mapped UART receiver, the input-side counterpart of `tx_uart` on the SoC bus. It samples the external `rx_line`, deframes 8N1 characters at a bit period set by the CPU through a configuration register, and buffers received bytes in a small first-word-fall-through (FWFT) FIFO. The CPU pops bytes and reads status through the SoC address decoder, at the `UART_RECV` and `UART_STATUS` addresses.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of 2, at least 2.
- `DEFAULT_DIVISOR`, default 103: divisor loaded at reset. Bit period P = divisor + 1 clocks.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `rx_line` input 1: asynchronous serial input; idles high.
- `config_data` input 8: new divisor value.
- `config_enable` input 1: loads `config_data` into the divisor on this edge.
- `read_enable` input 1: pops the FIFO head on this edge.
- `read_data` output 8: FIFO head; 0 when the FIFO is empty.
- `data_available` output 1: FIFO is non-empty.
- `overrun_error` output 1: sticky flag; a byte was dropped because the FIFO was full.
- `framing_error` output 1: sticky flag; a stop bit was sampled low.

## Operation
- Input synchronizer: two flops on `rx_line`. Both reset to 1. All logic below uses the synchronized value `rx_s`.
- Effective divisor: a written value below 3 is stored as 3, so P is at least 4.
- Receive state machine, with bit counter and period counter:
  - IDLE: on `rx_s` = 0, go to START and clear the period counter.
  - START: after floor(P/2) clocks, sample `rx_s`.
    - If 0, go to DATA.
    - If 1, treat the edge as a glitch and return to IDLE.
  - DATA: sample every P clocks, 8 bits, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample after P clocks.
    - If 1, push the byte and go to IDLE, mid-stop-bit, so back-to-back frames are received.
    - If 0, discard the byte, set `framing_error`, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This prevents a break from being read as a stream of frames.
- FIFO push:
  - If the FIFO is full and no pop happens in the same cycle, drop the byte and set `overrun_error`. FIFO contents are unchanged.
  - If the FIFO is full and a pop happens in the same cycle, the pop and the push both succeed and no overrun is flagged.
- FIFO pop (`read_enable`):
  - Non-empty: advance the read pointer; the next entry appears on `read_data` the following cycle.
  - Empty: no effect, no error.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; the extra MSB distinguishes full from empty.
- `config_enable`:
  - Loads the divisor.
  - Clears both sticky flags.
  - Aborts any frame in progress: the state goes to IDLE.
  - Does not flush the FIFO.
  - If `config_enable` and a stop-bit push fall on the same edge, the abort wins and no byte is pushed.

## Timing
- Reset values (`rst` = 0 at a rising edge):
  - state IDLE
  - FIFO empty
  - `read_data` = 0
  - `data_available` = 0
  - `overrun_error` = 0
  - `framing_error` = 0
  - divisor = `DEFAULT_DIVISOR`
  - synchronizer = 1
- A reset mid-frame discards the partial byte and all FIFO contents.
- Pin-to-`rx_s` latency: 2 clocks.
- Let t0 be the first edge at which `rx_s` = 0 in IDLE. Then:
  - start check at t0 + floor(P/2)
  - data bit i (i = 0..7) at t0 + floor(P/2) + (i+1)·P
  - stop bit at t0 + floor(P/2) + 9·P
- `data_available` rises, and `read_data` shows the byte, one cycle after the stop-bit sample edge.
- Flags set on the same cycle the byte would have been pushed.
- `read_data` and `data_available` are registered-state outputs with no combinational path from `read_enable`.

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles, `rx_line` = 1 for 2000 cycles → all outputs at 0, no push.
- Single frame, divisor 103 (P = 104): send 0xA5 → `data_available` = 1 exactly 2 + 52 + 9·104 + 1 cycles after the falling pin edge, `read_data` = 0xA5. Pulse `read_enable` → `data_available` = 0 and `read_data` = 0 next cycle.
- Overrun and wrap, divisor 3: send 0x01..0x06 back-to-back with no reads → FIFO holds 0x01..0x04, `overrun_error` = 1. Four pops return 0x01..0x04 in order. Send 0x07 → it reads correctly across the pointer wrap. A `config_enable` write clears the flag.
- Framing error and break: send 0x3C with the stop bit low, holding the line low for 30·P → `framing_error` = 1, nothing pushed. After the line returns high, 0x5A is received correctly.
- Glitch rejection: a 1-cycle low pulse on `rx_line` in IDLE → no push, no flags, state back in IDLE within P/2 + 3 cycles.
- Mid-frame reconfiguration: write `config_enable` with 0x01 during data bit 3 → frame aborted, divisor stored as 3. A subsequent frame 0xC3 sent at P = 4 is received as 0xC3.
